// File: rtl/sram2p_ctrl_pkg.sv
// Shared constants and types for the two-port SRAM request controller.
package sram2p_ctrl_pkg;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned WIDTH  = 36;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef logic [WIDTH-1:0]  sram_word_t;
  typedef logic [ADDR_W-1:0] sram_addr_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } init_state_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry registered response FIFO; head entry is presented combinationally.
module sram_rsp_fifo
  import sram2p_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  sram_word_t mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  // Storage, pointers and occupancy; push on a full FIFO is only ever paired with a pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram2p_req_ctrl.sv
// Request-side controller for a two-port 1024x36 SRAM macro (A: write, B: read).
// Optional post-reset zero fill is enabled by defining SRAM_INIT_CLEAR_EN.
module sram2p_req_ctrl
  import sram2p_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  output logic              init_busy,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH-1:0]  wr_be,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              CEBA,
  output logic              CEBB,
  output logic              WEBA,
  output logic              WEBB,
  output logic [ADDR_W-1:0] AA,
  output logic [ADDR_W-1:0] AB,
  output logic [WIDTH-1:0]  DA,
  output logic [WIDTH-1:0]  DB,
  output logic [WIDTH-1:0]  BWEBA,
  output logic [WIDTH-1:0]  BWEBB,
  input  logic [WIDTH-1:0]  QB
);

  logic       clr_fire;
  sram_addr_t clr_addr;
  logic       collide;
  logic       wr_fire;
  logic       rd_fire;
  logic       pop;
  logic       s1_valid_q;
  logic [1:0] fifo_count;
  logic [2:0] occ;

`ifdef SRAM_INIT_CLEAR_EN
  init_state_t state_q, state_d;
  sram_addr_t  clr_addr_q, clr_addr_d;

  // Clear FSM state and sweep address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Walk addresses 0..DEPTH-1 once, then hand over to normal traffic.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_fire   = 1'b0;
    unique case (state_q)
      CLEAR: begin
        // Keep the macro quiet while reset is still held.
        clr_fire   = reset_n;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == sram_addr_t'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
      end
    endcase
  end

  assign init_busy = (state_q == CLEAR);
  assign clr_addr  = clr_addr_q;
`else
  assign init_busy = 1'b0;
  assign clr_fire  = 1'b0;
  assign clr_addr  = '0;
`endif

  // Handshakes; a colliding read waits so the macro never sees write and read on one word.
  assign collide   = wr_valid & rd_valid & (wr_addr == rd_addr);
  assign wr_ready  = ~init_busy;
  assign rsp_valid = (fifo_count != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  // pop implies fifo_count >= 1, so occ cannot underflow.
  assign occ       = {1'b0, fifo_count} + {2'b0, s1_valid_q} - {2'b0, pop};
  assign rd_ready  = ~init_busy & ~collide & (occ < 3'd2);
  assign wr_fire   = wr_valid & wr_ready;
  assign rd_fire   = rd_valid & rd_ready;

  // Port A strobes: clear sweep or accepted write, otherwise idle.
  always_comb begin
    CEBA  = 1'b1;
    WEBA  = 1'b1;
    AA    = '0;
    DA    = '0;
    BWEBA = '1;
    if (clr_fire) begin
      CEBA  = 1'b0;
      WEBA  = 1'b0;
      AA    = clr_addr;
      BWEBA = '0;
    end else if (wr_fire) begin
      CEBA  = 1'b0;
      WEBA  = 1'b0;
      AA    = wr_addr;
      DA    = wr_data;
      BWEBA = ~wr_be;
    end
  end

  // Port B strobes: read-only port.
  always_comb begin
    CEBB  = ~rd_fire;
    WEBB  = 1'b1;
    AB    = rd_fire ? rd_addr : '0;
    DB    = '0;
    BWEBB = '1;
  end

  // QB is valid the cycle after the read strobe; track it for the FIFO push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_fire;
    end
  end

  sram_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (s1_valid_q),
    .push_data (QB),
    .pop       (pop),
    .count     (fifo_count),
    .head      (rsp_data)
  );

endmodule
